// File: rtl/mem_pkg.sv
// Shared encodings and requester identifiers for the scratchpad arbiter.
package mem_pkg;

  localparam logic [2:0] MT_B  = 3'd1;
  localparam logic [2:0] MT_H  = 3'd2;
  localparam logic [2:0] MT_W  = 3'd3;
  localparam logic [2:0] MT_BU = 3'd5;
  localparam logic [2:0] MT_HU = 3'd6;

  localparam logic M_XRD = 1'b0;
  localparam logic M_XWR = 1'b1;

  typedef logic [1:0] req_id_t;

  localparam req_id_t REQ_IMEM = 2'd0;
  localparam req_id_t REQ_DMEM = 2'd1;
  localparam req_id_t REQ_HTIF = 2'd2;
  localparam int unsigned NUM_REQ = 3;

  // Round-robin successor, wrapping htif back to imem.
  function automatic req_id_t next_id(input req_id_t id);
    return (id == REQ_HTIF) ? REQ_IMEM : req_id_t'(id + 2'd1);
  endfunction

endpackage

// File: rtl/mem_wmask_gen.sv
// Byte write-enable generator: misaligned or unknown access types yield an empty mask.
module mem_wmask_gen
  import mem_pkg::*;
#(
  parameter int unsigned SW = 4
) (
  input  logic [2:0]    typ_i,
  input  logic [1:0]    addr_i,
  output logic [SW-1:0] mask_o
);

  always_comb begin
    mask_o = '0;
    case (typ_i)
      MT_B, MT_BU: mask_o = SW'(1) << addr_i;
      MT_H, MT_HU: begin
        if (!addr_i[0]) mask_o = SW'(3) << addr_i;
      end
      MT_W: begin
        if (addr_i == 2'b00) mask_o = '1;
      end
      default: mask_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read scratchpad among imem, dmem and htif;
// each response is routed back to the requester granted in the previous cycle.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned SW = DW / 8
) (
  input  logic          clk_i,
  input  logic          reset_i,

  input  logic          imem_req_valid_i,
  output logic          imem_req_ready_o,
  input  logic [AW-1:0] imem_req_addr_i,
  output logic          imem_resp_valid_o,
  output logic [DW-1:0] imem_resp_data_o,

  input  logic          dmem_req_valid_i,
  output logic          dmem_req_ready_o,
  input  logic [AW-1:0] dmem_req_addr_i,
  input  logic [DW-1:0] dmem_req_data_i,
  input  logic          dmem_req_fcn_i,
  input  logic [2:0]    dmem_req_typ_i,
  output logic          dmem_resp_valid_o,
  output logic [DW-1:0] dmem_resp_data_o,

  input  logic          htif_req_valid_i,
  output logic          htif_req_ready_o,
  input  logic [AW-1:0] htif_req_addr_i,
  input  logic [DW-1:0] htif_req_data_i,
  input  logic          htif_req_fcn_i,
  input  logic [2:0]    htif_req_typ_i,
  output logic          htif_resp_valid_o,
  output logic [DW-1:0] htif_resp_data_o,

  output logic          mem_req_valid_o,
  output logic [AW-3:0] mem_req_addr_o,
  output logic          mem_req_wen_o,
  output logic [SW-1:0] mem_req_wmask_o,
  output logic [DW-1:0] mem_req_data_o,
  input  logic [DW-1:0] mem_resp_data_i
);

  req_id_t last_grant_q, last_grant_d;
  req_id_t resp_id_q, resp_id_d;
  logic    resp_pend_q, resp_pend_d;

  logic [NUM_REQ-1:0] req_valid;
  logic               grant_valid;
  req_id_t            grant_id;
  req_id_t            cand;

  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic          sel_fcn;
  logic [2:0]    sel_typ;
  logic [SW-1:0] gen_mask;
  logic          resp_live;

  assign req_valid = {htif_req_valid_i, dmem_req_valid_i, imem_req_valid_i};

  // Walk the three requesters starting just after the last winner.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = last_grant_q;
    cand        = next_id(last_grant_q);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_valid && req_valid[cand]) begin
        grant_valid = 1'b1;
        grant_id    = cand;
      end
      cand = next_id(cand);
    end
    if (reset_i) grant_valid = 1'b0;
  end

  // imem is fetch-only, so it presents as an aligned word read.
  always_comb begin
    sel_addr = imem_req_addr_i;
    sel_data = '0;
    sel_fcn  = M_XRD;
    sel_typ  = MT_W;
    case (grant_id)
      REQ_DMEM: begin
        sel_addr = dmem_req_addr_i;
        sel_data = dmem_req_data_i;
        sel_fcn  = dmem_req_fcn_i;
        sel_typ  = dmem_req_typ_i;
      end
      REQ_HTIF: begin
        sel_addr = htif_req_addr_i;
        sel_data = htif_req_data_i;
        sel_fcn  = htif_req_fcn_i;
        sel_typ  = htif_req_typ_i;
      end
      default: ;
    endcase
  end

  mem_wmask_gen #(
    .SW (SW)
  ) u_wmask_gen (
    .typ_i  (sel_typ),
    .addr_i (sel_addr[1:0]),
    .mask_o (gen_mask)
  );

  always_comb begin
    mem_req_valid_o = grant_valid;
    mem_req_addr_o  = sel_addr[AW-1:2];
    mem_req_wen_o   = grant_valid && (sel_fcn == M_XWR);
    mem_req_wmask_o = mem_req_wen_o ? gen_mask : '0;
    mem_req_data_o  = sel_data;

    imem_req_ready_o = grant_valid && (grant_id == REQ_IMEM);
    dmem_req_ready_o = grant_valid && (grant_id == REQ_DMEM);
    htif_req_ready_o = grant_valid && (grant_id == REQ_HTIF);
  end

  always_comb begin
    last_grant_d = grant_valid ? grant_id : last_grant_q;
    resp_pend_d  = grant_valid;
    resp_id_d    = grant_valid ? grant_id : resp_id_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_grant_q <= REQ_HTIF;
      resp_pend_q  <= 1'b0;
      resp_id_q    <= REQ_IMEM;
    end else begin
      last_grant_q <= last_grant_d;
      resp_pend_q  <= resp_pend_d;
      resp_id_q    <= resp_id_d;
    end
  end

  // A response still in flight when reset rises is suppressed immediately.
  assign resp_live = resp_pend_q && !reset_i;

  always_comb begin
    imem_resp_valid_o = resp_live && (resp_id_q == REQ_IMEM);
    dmem_resp_valid_o = resp_live && (resp_id_q == REQ_DMEM);
    htif_resp_valid_o = resp_live && (resp_id_q == REQ_HTIF);
    imem_resp_data_o  = mem_resp_data_i;
    dmem_resp_data_o  = mem_resp_data_i;
    htif_resp_data_o  = mem_resp_data_i;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port, synchronous-read scratchpad between three requesters: instruction fetch (imem), data access (dmem) and the host-target interface (htif). Grants at most one request per cycle, round-robin, drives the memory port with a byte write mask derived from the access type, and routes each memory response back to the requester that issued it. Sits between the core/HTIF and the scratchpad memory macro.

## Interface
- AW, 32, address width
- DW, 32, data width
- SW, DW/8, bytes per word (write-mask width)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- imem_req_valid / imem_req_ready  in/out  1/1  fetch handshake (read-only)
- imem_req_addr  in  AW  fetch byte address
- imem_resp_valid / imem_resp_data  out  1/DW  fetch response
- dmem_req_valid / dmem_req_ready  in/out  1/1  data handshake
- dmem_req_addr / dmem_req_data  in  AW/DW  address, write data
- dmem_req_fcn  in  1  0 = read, 1 = write
- dmem_req_typ  in  3  MT_B=1, MT_H=2, MT_W=3, MT_BU=5, MT_HU=6
- dmem_resp_valid / dmem_resp_data  out  1/DW  data response
- htif_req_*, htif_resp_*: same set and widths as dmem
- mem_req_valid  out  1  memory access this cycle
- mem_req_addr  out  AW-2  word index (byte address >> 2)
- mem_req_wen  out  1  write enable
- mem_req_wmask  out  SW  byte enables, bit i = byte i
- mem_req_data  out  DW  write data, already lane-aligned by requester
- mem_resp_data  in  DW  read data, valid the cycle after mem_req_valid

## Operation
- Requester index: imem=0, dmem=1, htif=2. A 2-bit last_grant register; priority starts at (last_grant+1) mod 3 and wraps.
- Each cycle, grant the highest-priority valid requester. Only that requester sees req_ready=1; req_ready is combinational from the valids and last_grant. last_grant updates only on a grant.
- Accepted read: mem_req_valid=1, wen=0, wmask=0.
- Accepted write: wen=1; wmask from typ and addr[1:0]. B/BU: 1<<addr[1:0]. H/HU: 0b0011<<addr[1:0] if addr[0]=0, else 0. W: 0b1111 if addr[1:0]=0, else 0. Any other typ: 0.
- Misaligned or invalid writes use a zero mask, so no byte is written. They still get a response.
- Response tracking: registered resp_pend (1 bit) and resp_id (2 bits) capture the grant. Next cycle, exactly one of *_resp_valid is asserted for resp_id. Its resp_data = mem_resp_data. For writes, the data is don't-care and acts as an acknowledgement.
- No back-pressure on responses; requesters must accept resp_valid.

## Timing
- Reset values: last_grant=2 (imem wins first), resp_pend=0, all *_resp_valid=0.
- Reset takes effect at the clock edge where reset=1. A response pending at that edge is dropped. All req_ready are 0 while reset=1.
- Latency: accepted request in cycle N gives resp_valid in cycle N+1. Throughput: one access per cycle, back-to-back, no bubbles.
- Simultaneous valid from all three, held constant, gives grant order 0,1,2,0,1,2… Each requester is starved at most 2 cycles.
- A request whose valid drops before being granted is not remembered.
- Two writes to the same word in consecutive cycles are both performed, in grant order.

## Structure
- Package mem_pkg holds:
  - typ encodings (MT_B…MT_HU) and fcn encodings (M_XRD=0, M_XWR=1);
  - requester index constants;
  - typedef req_id_t (logic [1:0]).
- Sub-module mem_wmask_gen: combinational; inputs typ and addr[1:0]; output mask[SW-1:0]. Verified standalone.
- Round-robin grant, response registers and output muxing live in mem_arbiter.

## Test plan
- Reset then imem read of addr 0x10 (memory word 4 = 0xDEADBEEF): imem_req_ready same cycle; next cycle imem_resp_valid=1, data=0xDEADBEEF; dmem/htif resp_valid=0.
- dmem write SB, addr 0x0103, data 0xAA000000: mem_req_addr=0x40, wmask=0b1000. Then SH at 0x0102 gives 0b1100; SH at 0x0101 gives 0b0000; SW at 0x0100 gives 0b1111.
- All three valid for 6 cycles starting after reset: grants imem, dmem, htif, imem, dmem, htif. Each resp_valid arrives 1 cycle after its grant with the correct routed data.
- htif writes 0x12345678 to 0x200, then dmem reads 0x200 the next cycle: dmem_resp_data=0x12345678.
- Assert reset in the cycle after a dmem read is granted: no dmem_resp_valid; the first grant after reset goes to imem.
- Only dmem valid for 4 cycles: granted every cycle; last_grant=1 afterwards; then simultaneous imem+htif grants htif first.
